// File: rtl/divider_datapath.sv
// Shift/subtract datapath for a restoring divider: executes the controller's
// Sh/Ld commands, returns compare bit C, and flags overflow, completion and protocol errors.
module divider_datapath #(
  parameter int N = 4
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           St,
  input  logic           Ld,
  input  logic           Sh,
  input  logic [2*N-1:0] Dividend,
  input  logic [N-1:0]   Divisor,
  output logic           C,
  output logic [N-1:0]   Quotient,
  output logic [N-1:0]   Remainder,
  output logic           V,
  output logic           Done,
  output logic           Err
);
  localparam int CW = $clog2(N+1);
  localparam logic [CW-1:0] CNT_MAX = CW'(N);

  logic [2*N:0]  x;
  logic [N-1:0]  y;
  logic [CW-1:0] cnt;
  logic          loaded;
  logic          v_q, done_q, err_q;

  logic [N:0]    upper;
  logic [N:0]    diff;
  logic [CW-1:0] cnt_inc;
  logic          sh_ok, ld_ok, illegal;

  assign upper   = x[2*N:N];
  assign diff    = upper - {1'b0, y};
  assign cnt_inc = cnt + 1'b1;

  assign C = (upper >= {1'b0, y});

  // A command is only legal on a captured, non-overflowed operand set.
  assign sh_ok   = loaded && !v_q && (cnt != CNT_MAX);
  assign ld_ok   = loaded && !v_q && C;
  assign illegal = (Sh && Ld) || (Sh && !sh_ok) || (Ld && !ld_ok);

  always_ff @(posedge CLK) begin
    if (RST) begin
      x      <= '0;
      y      <= '0;
      cnt    <= '0;
      loaded <= 1'b0;
      v_q    <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (St) begin
      x      <= {1'b0, Dividend};
      y      <= Divisor;
      cnt    <= '0;
      loaded <= 1'b1;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      v_q    <= (Divisor == '0) || (Dividend[2*N-1:N] >= Divisor);
    end else if (Sh || Ld) begin
      if (illegal) begin
        err_q <= 1'b1;
      end else if (Sh) begin
        x   <= {x[2*N-1:0], 1'b0};
        cnt <= cnt_inc;
        if (cnt_inc == CNT_MAX) done_q <= 1'b1;
      end else begin
        // Upper part takes the difference; the freed LSB records the quotient bit.
        x[2*N:N] <= diff;
        x[0]     <= 1'b1;
      end
    end
  end

  assign Quotient  = x[N-1:0];
  assign Remainder = x[2*N-1:N];
  assign V         = v_q;
  assign Done      = done_q;
  assign Err       = err_q;

endmodule

// File: tb/tb_divider_datapath.sv
// Directed bench for divider_datapath (N=4) with hand-computed expectations.
module tb_divider_datapath;
  localparam int N = 4;

  logic           CLK = 1'b0;
  logic           RST, St, Ld, Sh;
  logic [2*N-1:0] Dividend;
  logic [N-1:0]   Divisor;
  logic           C, V, Done, Err;
  logic [N-1:0]   Quotient, Remainder;

  int tests = 0;
  int fails = 0;

  divider_datapath #(.N(N)) dut (
    .CLK(CLK), .RST(RST), .St(St), .Ld(Ld), .Sh(Sh),
    .Dividend(Dividend), .Divisor(Divisor),
    .C(C), .Quotient(Quotient), .Remainder(Remainder),
    .V(V), .Done(Done), .Err(Err)
  );

  always #5 CLK = ~CLK;

  // Drive one command cycle, then sample 1 time unit after the edge.
  task automatic cycle(input logic rst, input logic st, input logic sh, input logic ld,
                       input logic [2*N-1:0] dd, input logic [N-1:0] dv);
    RST = rst; St = st; Sh = sh; Ld = ld; Dividend = dd; Divisor = dv;
    @(posedge CLK); #1;
    RST = 1'b0; St = 1'b0; Sh = 1'b0; Ld = 1'b0;
  endtask

  task automatic test_reset;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
    tests++;
    if ({Quotient, Remainder, V, Done, Err, C} !== {4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL reset: got q=%0d r=%0d v=%b d=%b e=%b c=%b want q=0 r=0 v=0 d=0 e=0 c=1",
               Quotient, Remainder, V, Done, Err, C);
    end
  endtask

  task automatic test_divide;
    // 135 / 13 = 10 rem 5; C sequence after each step precomputed below.
    logic [4:0] ops [6] = '{5'b10_000, 5'b01_000, 5'b10_000, 5'b10_000, 5'b01_000, 5'b10_000};
    logic       exp_c [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0] exp_x [6] = '{8'h3F, 8'h3F, 8'h7E, 8'hFC, 8'h2D, 8'h5A};
    logic       c_after_sh [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h87, 4'd13);
    tests++;
    if ({V, C, Remainder, Quotient} !== {1'b0, 1'b0, 8'h87}) begin
      fails++;
      $display("FAIL div_load: got v=%b c=%b x=%h want v=0 c=0 x=87", V, C, {Remainder, Quotient});
    end
    // Step 0: Sh -> X=1_0000_1110, C=1
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'h0);
    tests++;
    if ({C, Remainder, Quotient} !== {c_after_sh[0], 8'h0E}) begin
      fails++;
      $display("FAIL div_sh1: got c=%b x=%h want c=1 x=0e", C, {Remainder, Quotient});
    end
    for (int i = 1; i < 6; i++) begin
      cycle(1'b0, 1'b0, ops[i][4], ops[i][3], 8'h00, 4'h0);
      tests++;
      if ({C, Remainder, Quotient} !== {c_after_sh[i], exp_x[i]}) begin
        fails++;
        $display("FAIL div_step%0d: got c=%b x=%h want c=%b x=%h",
                 i, C, {Remainder, Quotient}, c_after_sh[i], exp_x[i]);
      end
    end
    tests++;
    if ({Quotient, Remainder, Done, V, Err} !== {4'd10, 4'd5, 1'b1, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL div_result: got q=%0d r=%0d d=%b v=%b e=%b want q=10 r=5 d=1 v=0 e=0",
               Quotient, Remainder, Done, V, Err);
    end
    if (exp_c[0] !== 1'b0) $display("unreachable");
  endtask

  task automatic test_overflow;
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'hD0, 4'd13);
    tests++;
    if ({V, Done, Err} !== 3'b100) begin
      fails++;
      $display("FAIL ovf_v: got v=%b d=%b e=%b want v=1 d=0 e=0", V, Done, Err);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'h0);
    tests++;
    if ({Remainder, Quotient, Err, V} !== {8'hD0, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL ovf_sh: got x=%h e=%b v=%b want x=d0 e=1 v=1", {Remainder, Quotient}, Err, V);
    end
  endtask

  task automatic test_div_zero;
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h05, 4'd0);
    tests++;
    if ({V, Done, Err} !== 3'b100) begin
      fails++;
      $display("FAIL divzero: got v=%b d=%b e=%b want v=1 d=0 e=0", V, Done, Err);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 4'h0);
    tests++;
    if ({Remainder, Quotient, Done, Err} !== {8'h05, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL divzero_ld: got x=%h d=%b e=%b want x=05 d=0 e=1", {Remainder, Quotient}, Done, Err);
    end
  endtask

  task automatic test_sh_ld_both;
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h87, 4'd13);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 4'h0);
    tests++;
    if ({Remainder, Quotient, Err, Done} !== {8'h87, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL both_cmd: got x=%h e=%b d=%b want x=87 e=1 d=0", {Remainder, Quotient}, Err, Done);
    end
    // cnt must still be 0: four legal shifts are needed before Done rises
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'h0);
    tests++;
    if (Done !== 1'b0) begin
      fails++;
      $display("FAIL both_cnt: got done=%b want done=0 after 3 shifts", Done);
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h87, 4'd13);
    tests++;
    if ({Err, V, Done} !== 3'b000) begin
      fails++;
      $display("FAIL st_clears: got e=%b v=%b d=%b want 0 0 0", Err, V, Done);
    end
  endtask

  task automatic test_extra_shift;
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h87, 4'd13);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'h0);
    tests++;
    if ({Remainder, Quotient, Done, Err} !== {8'h70, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL four_sh: got x=%h d=%b e=%b want x=70 d=1 e=0", {Remainder, Quotient}, Done, Err);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'h0);
    tests++;
    if ({Remainder, Quotient, Done, Err} !== {8'h70, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL fifth_sh: got x=%h d=%b e=%b want x=70 d=1 e=1", {Remainder, Quotient}, Done, Err);
    end
  endtask

  task automatic test_reset_mid;
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h87, 4'd13);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'h0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'h0);
    // RST wins over a simultaneous St
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 4'd1);
    tests++;
    if ({Remainder, Quotient, Done, V, Err, C} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL rst_mid: got x=%h d=%b v=%b e=%b c=%b want x=00 d=0 v=0 e=0 c=1",
               {Remainder, Quotient}, Done, V, Err, C);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'h0);
    tests++;
    if ({Remainder, Quotient, Err} !== {8'h00, 1'b1}) begin
      fails++;
      $display("FAIL unloaded_sh: got x=%h e=%b want x=00 e=1", {Remainder, Quotient}, Err);
    end
  endtask

  initial begin
    RST = 1'b0; St = 1'b0; Sh = 1'b0; Ld = 1'b0; Dividend = '0; Divisor = '0;
    @(negedge CLK);
    test_reset();
    test_divide();
    test_overflow();
    test_div_zero();
    test_sh_ld_both();
    test_extra_shift();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/divider_datapath.md
Name: divider_datapath

Overview:
Shift/subtract datapath that sits at the far end of the division controller's Sh/Ld/C interface. It holds the dividend/partial remainder and divisor, executes the controller's shift and load-difference commands, and returns the compare bit C. It also flags divide overflow, counts shifts to signal completion, and checks that the controller obeys the command protocol.

Parameters:
N, 4, divisor width and quotient width; the dividend is 2N bits.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
RST  input  1  synchronous reset, active-high.
St  input  1  start; captures operands and clears working state.
Ld  input  1  load-difference command: the upper partial remainder becomes (upper - divisor) and quotient bit 0 is set.
Sh  input  1  shift command: the working register shifts left by one.
Dividend  input  2N  dividend operand, sampled when St=1.
Divisor  input  N  divisor operand, sampled when St=1.
C  output  1  compare: upper partial remainder >= divisor (combinational from registers).
Quotient  output  N  quotient, equal to X[N-1:0].
Remainder  output  N  remainder, equal to X[2N-1:N].
V  output  1  overflow or divide-by-zero, registered and sticky until the next St or RST.
Done  output  1  registered; high once N shifts have completed.
Err  output  1  sticky protocol-violation flag.

Behaviour:
- Registers:
  - X, 2N+1 bits: working register.
  - Y, N bits: divisor.
  - cnt, ceil(log2(N+1)) bits: shift counter, range 0..N.
  - loaded flag: an operand set has been captured since the last reset.
  - V, Done, Err.
- Reset (RST=1 at a rising edge): X=0, Y=0, cnt=0, loaded=0, V=0, Done=0, Err=0. RST overrides all other inputs, including mid-operation.
- C = (X[2N:N] >= {1'b0,Y}), unsigned and combinational. After reset C=1, because 0 >= 0.
- Command priority at each edge: RST, then St, then Sh/Ld.
- St=1:
  - X <= {1'b0, Dividend}; Y <= Divisor; cnt <= 0; Done <= 0; Err <= 0; loaded <= 1.
  - V <= (Divisor==0) or (Dividend[2N-1:N] >= Divisor).
  - Any Sh/Ld in the same cycle is ignored and not flagged.
- Sh=1 alone, legal case (loaded=1, V=0, cnt<N):
  - X <= {X[2N-1:0], 1'b0}; cnt <= cnt+1.
  - Done <= 1 when cnt+1 == N.
- Ld=1 alone, legal case (loaded=1, V=0, C=1):
  - X[2N:N] <= X[2N:N] - {1'b0,Y}, truncated to N+1 bits; X[0] <= 1.
  - cnt is unchanged. Ld is legal while cnt==N, so the final subtract after the last shift is allowed.
- Illegal commands: X, cnt and Done hold, and Err <= 1. The illegal cases are:
  - Sh and Ld both high;
  - Sh with cnt==N;
  - Ld with C==0;
  - Sh or Ld with loaded==0 or V==1.
- No command: all state holds.
- Result validity:
  - Quotient and Remainder are final once Done=1 and the controller has issued its optional last Ld.
  - The datapath does not gate them; they always mirror X.
- Latency: one operation takes 1 St cycle + N Sh cycles + up to N Ld cycles. V is valid one cycle after St.
- Width rule: with V=0, the value after subtraction always fits in N bits, so X[2N] is 0 after every legal Ld.

Test Plan:
- N=4, St with Dividend=135 (0x87), Divisor=13; then Sh,Ld,Sh,Sh,Ld,Sh driven per C:
  - C=1 after shift 1 and after shift 3;
  - final result Quotient=10, Remainder=5, Done=1, V=0, Err=0.
- St with Dividend=0xD0, Divisor=13 -> V=1 the next cycle. A following Sh leaves X unchanged and sets Err=1.
- St with Divisor=0 (any dividend) -> V=1; Done stays 0.
- After a legal load of 135/13: Sh=1 and Ld=1 in the same cycle -> X and cnt hold, Err=1. A new St clears Err to 0.
- Complete 4 shifts (Done=1), then a 5th Sh -> cnt stays 4, X holds, Err=1.
- Reset mid-operation: after 2 shifts assert RST -> next cycle X=0, Done=0, V=0, Err=0, C=1. A subsequent Sh sets Err=1 because no operands are loaded.
